// File: rtl/demux4_router.sv
// demux4_router: 1-to-4 word router with an independent 2-entry FIFO per
// destination channel.
//
// Ports:
//   clock      rising-edge clock
//   resetn     asynchronous active-low reset (clears counts, pointers, storage)
//   in_data    upstream word
//   in_sel     destination channel (0..3)
//   in_valid   upstream offers in_data/in_sel
//   in_ready   combinational: destination FIFO of in_sel has room
//   out_data   channel k head word on [k*WIDTH +: WIDTH], zero when empty
//   out_valid  bit k = channel k holds at least one word
//   out_ready  bit k = channel k sink consumes its head this cycle
//
// Optional feature (macro DEMUX4_ROUTER_STATS_EN):
//   stat_clr   synchronous clear of the transfer counters (beats increments)
//   stat_xfer  four saturating 8-bit input-transfer counters, channel k on
//              [8k+7:8k]
module demux4_router #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready
`ifdef DEMUX4_ROUTER_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_xfer
`endif
);

  logic [WIDTH-1:0] mem   [4][2];
  logic [1:0]       count [4];
  logic [3:0]       wptr;
  logic [3:0]       rptr;
  logic [3:0]       push;
  logic [3:0]       pop;

  // Readiness depends only on the selected channel's occupancy.
  always_comb begin
    in_ready = (count[in_sel] < 2'd2);
  end

  always_comb begin
    push = '0;
    if (in_valid && in_ready) begin
      push[in_sel] = 1'b1;
    end
  end

  // Outputs are a direct view of registered state; the empty case forces
  // zeros so stale storage never leaks to the sink.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    pop       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      out_valid[k] = (count[k] != 2'd0);
      pop[k]       = out_valid[k] && out_ready[k];
      if (out_valid[k]) begin
        out_data[k*WIDTH +: WIDTH] = mem[k][rptr[k]];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        count[k]  <= '0;
        mem[k][0] <= '0;
        mem[k][1] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (push[k]) begin
          mem[k][wptr[k]] <= in_data;
          wptr[k]         <= ~wptr[k];
        end
        if (pop[k]) begin
          rptr[k] <= ~rptr[k];
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 2'd1;
          2'b01:   count[k] <= count[k] - 2'd1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

`ifdef DEMUX4_ROUTER_STATS_EN
  logic [7:0] xfer [4];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < 4; k++) begin
        xfer[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (stat_clr) begin
          xfer[k] <= '0;
        end else if (push[k] && (xfer[k] != 8'hFF)) begin
          xfer[k] <= xfer[k] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    stat_xfer = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      stat_xfer[k*8 +: 8] = xfer[k];
    end
  end
`endif

endmodule

// File: tb/tb_demux4_router.sv
// Testbench for demux4_router. A queue-per-channel reference model predicts
// every output; each scenario task compares the DUT against it.
module tb_demux4_router;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           resetn;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
`ifdef DEMUX4_ROUTER_STATS_EN
  logic           stat_clr;
  logic [31:0]    stat_xfer;
`endif

  demux4_router #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX4_ROUTER_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_xfer (stat_xfer)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: one FIFO queue per channel plus transfer counters.
  logic [W-1:0] mq [4][$];
  int unsigned  mstat [4];
  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [3:0] exp_valid();
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k] = (mq[k].size() != 0);
    return r;
  endfunction

  function automatic logic [4*W-1:0] exp_data();
    logic [4*W-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      if (mq[k].size() != 0) r[k*W +: W] = mq[k][0];
    return r;
  endfunction

  function automatic logic [31:0] exp_stat();
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = mstat[k][7:0];
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mstat[k] = 0;
    end
  endfunction

  // Drive one clock cycle and advance the model; no checking here.
  task automatic cycle(input logic v, input logic [1:0] sel,
                       input logic [W-1:0] d, input logic [3:0] ordy);
    bit acc;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    acc = v && (mq[sel].size() < 2);
    @(posedge clock);
    for (int k = 0; k < 4; k++)
      if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
    if (acc) mq[sel].push_back(d);
`ifdef DEMUX4_ROUTER_STATS_EN
    if (stat_clr) begin
      for (int k = 0; k < 4; k++) mstat[k] = 0;
    end else if (acc && mstat[sel] < 255) begin
      mstat[sel]++;
    end
`else
    if (acc) mstat[sel]++;
`endif
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
`ifdef DEMUX4_ROUTER_STATS_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    #1;
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL reset_valid got=%b exp=0000", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== '0) $display("FAIL reset_data got=%h exp=0", out_data);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    cycle(1'b1, 2'd2, 8'hA5, 4'b0000);
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 4'b0100) $display("FAIL basic_valid got=%b exp=0100", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data[23:16] !== 8'hA5) $display("FAIL basic_data got=%h exp=a5", out_data[23:16]);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL basic_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    cycle(1'b0, 2'd0, 8'h00, 4'b1111);
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL basic_drain got=%b exp=0000", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    cycle(1'b1, 2'd1, 8'h11, 4'b0000);
    cycle(1'b1, 2'd1, 8'h22, 4'b0000);
    in_valid = 1'b0;
    in_sel = 2'd1; #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", in_ready);
    else pass_cnt++;
    in_sel = 2'd0; #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_other_ready got=%b exp=1", in_ready);
    else pass_cnt++;
    // Offer to a full channel: must be ignored.
    cycle(1'b1, 2'd1, 8'h99, 4'b0000);
    total_cnt++;
    if (out_data[15:8] !== 8'h11) $display("FAIL bp_head got=%h exp=11", out_data[15:8]);
    else pass_cnt++;
    cycle(1'b0, 2'd1, 8'h00, 4'b0010);
    total_cnt++;
    if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h22)
      $display("FAIL bp_pop1 got=%b/%h exp=1/22", out_valid[1], out_data[15:8]);
    else pass_cnt++;
    cycle(1'b0, 2'd1, 8'h00, 4'b0010);
    total_cnt++;
    if (out_valid !== exp_valid() || out_data !== exp_data())
      $display("FAIL bp_pop2 got=%b/%h exp=%b/%h", out_valid, out_data, exp_valid(), exp_data());
    else pass_cnt++;
  endtask

  task automatic test_simul_push_pop();
    cycle(1'b1, 2'd3, 8'h30, 4'b0000);
    cycle(1'b1, 2'd3, 8'h33, 4'b1000);
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid[3] !== 1'b1 || out_data[31:24] !== 8'h33)
      $display("FAIL simul_head got=%b/%h exp=1/33", out_valid[3], out_data[31:24]);
    else pass_cnt++;
    cycle(1'b0, 2'd0, 8'h00, 4'b1000);
    total_cnt++;
    if (out_valid[3] !== 1'b0) $display("FAIL simul_count got=%b exp=0", out_valid[3]);
    else pass_cnt++;
  endtask

  task automatic test_isolation();
    cycle(1'b1, 2'd0, 8'hC0, 4'b0000);
    cycle(1'b1, 2'd0, 8'hC1, 4'b0000);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 2'd2, W'(i), 4'b0100);
      total_cnt++;
      if (out_valid !== 4'b0101 || out_data[23:16] !== W'(i) || out_data[7:0] !== 8'hC0)
        $display("FAIL iso_step%0d got=%b/%h exp=0101 ch2=%h ch0=c0", i, out_valid, out_data, W'(i));
      else pass_cnt++;
    end
    cycle(1'b0, 2'd0, 8'h00, 4'b0100);
    total_cnt++;
    if (out_valid !== exp_valid() || out_data !== exp_data())
      $display("FAIL iso_end got=%b/%h exp=%b/%h", out_valid, out_data, exp_valid(), exp_data());
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 2'd1, 8'h10, 4'b0000);
    cycle(1'b1, 2'd1, 8'h11, 4'b0000);
    cycle(1'b1, 2'd0, 8'hC2, 4'b0000);
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 4'b0011) $display("FAIL ar_pre got=%b exp=0011", out_valid);
    else pass_cnt++;
    @(negedge clock);
    resetn = 1'b0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h77; out_ready = 4'b1111;
    #1;
    total_cnt++;
    if (out_valid !== 4'b0000 || out_data !== '0 || in_ready !== 1'b1)
      $display("FAIL ar_immediate got=%b/%h/%b exp=0000/0/1", out_valid, out_data, in_ready);
    else pass_cnt++;
    model_reset();
    @(posedge clock);
    #1;
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL ar_no_xfer got=%b exp=0000", out_valid);
    else pass_cnt++;
    @(negedge clock);
    resetn = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    logic [1:0] s;
    logic       v;
    logic [3:0] r;
    logic [W-1:0] d;
    for (int i = 0; i < 400; i++) begin
      s = 2'($urandom_range(0, 3));
      v = 1'($urandom_range(0, 3) != 0);
      r = 4'($urandom);
      d = W'($urandom);
      in_sel = s;
      #1;
      total_cnt++;
      if (in_ready !== (mq[s].size() < 2))
        $display("FAIL rand_ready%0d got=%b exp=%b", i, in_ready, (mq[s].size() < 2));
      else pass_cnt++;
      cycle(v, s, d, r);
      total_cnt++;
      if (out_valid !== exp_valid() || out_data !== exp_data())
        $display("FAIL rand_out%0d got=%b/%h exp=%b/%h", i, out_valid, out_data, exp_valid(), exp_data());
      else pass_cnt++;
    end
    in_valid = 1'b0;
  endtask

`ifdef DEMUX4_ROUTER_STATS_EN
  task automatic test_stats();
    total_cnt++;
    if (stat_xfer !== exp_stat()) $display("FAIL stat_pre got=%h exp=%h", stat_xfer, exp_stat());
    else pass_cnt++;
    for (int i = 0; i < 300; i++) cycle(1'b1, 2'd0, W'(i), 4'b0001);
    total_cnt++;
    if (stat_xfer[7:0] !== 8'd255 || stat_xfer !== exp_stat())
      $display("FAIL stat_sat got=%h exp=%h", stat_xfer, exp_stat());
    else pass_cnt++;
    stat_clr = 1'b1;
    cycle(1'b1, 2'd1, 8'h5A, 4'b1111);
    stat_clr = 1'b0;
    in_valid = 1'b0;
    total_cnt++;
    if (stat_xfer !== 32'd0) $display("FAIL stat_clr got=%h exp=0", stat_xfer);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simul_push_pop();
    test_isolation();
    test_async_reset();
    test_random();
`ifdef DEMUX4_ROUTER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/demux4_router.md
DEMUX4_ROUTER -- requirements
Module: demux4_router

Interface
REQ-001 The parameter SHALL be: WIDTH, 8, data word width in bits (legal range 1..32).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: in_data  input  WIDTH  word offered by the upstream source.
REQ-005 Port: in_sel  input  2  destination channel (0..3) of in_data.
REQ-006 Port: in_valid  input  1  upstream offers in_data/in_sel this cycle.
REQ-007 Port: in_ready  output  1  block accepts the offered word this cycle.
REQ-008 Port: out_data  output  4*WIDTH  channel k head word on bits [k*WIDTH +: WIDTH].
REQ-009 Port: out_valid  output  4  bit k set = channel k head word valid.
REQ-010 Port: out_ready  input  4  bit k set = channel k sink consumes head this cycle.

Function
REQ-011 Each channel k SHALL own an independent 2-entry FIFO with a 2-bit occupancy count (0..2).
REQ-012 in_ready SHALL be combinational: 1 when count[in_sel] < 2, else 0. It does not depend on in_valid or out_ready.
REQ-013 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1. The word is written to the tail of FIFO in_sel only.
REQ-014 An output transfer on channel k SHALL occur on a rising edge with out_valid[k]=1 and out_ready[k]=1. The head entry is then popped.
REQ-015 out_valid[k] SHALL equal (count[k] != 0), driven from registers. out_data slice k SHALL show the head entry, or all zeros when count[k]=0.
REQ-016 Latency SHALL be 1 cycle: a word accepted at edge N into an empty channel is visible at the output after edge N. There is no combinational in->out bypass.
REQ-017 Simultaneous push and pop on the same channel SHALL leave the count unchanged and preserve order. At count 2 no push is possible (REQ-012).
REQ-018 Push on one channel and pop on another in the same cycle SHALL each take effect independently.
REQ-019 Words SHALL leave each channel in arrival order. A stalled channel SHALL never block transfers to other channels.
REQ-020 out_ready[k] asserted while out_valid[k]=0 SHALL have no effect. in_sel and in_data SHALL be ignored when in_valid=0.
REQ-021 Read and write pointers SHALL be 1 bit each and wrap from 1 to 0.

Reset
REQ-022 When resetn=0, the block SHALL asynchronously clear all counts, pointers and storage. Resulting outputs: out_valid=4'b0000, out_data=0, in_ready=1.
REQ-023 Reset asserted mid-transfer SHALL discard all buffered words. No transfer completes on the edge where resetn is low.
REQ-024 Deassertion SHALL take effect on the first rising edge with resetn=1.

Configuration
REQ-025 Macro DEMUX4_ROUTER_STATS_EN SHALL control the statistics feature.
- Defined: adds ports stat_clr (input, 1 bit) and stat_xfer (output, 32 bits).
- stat_xfer bits [8k+7:8k] hold a saturating 8-bit count of input transfers to channel k. The count sticks at 255.
- stat_clr=1 synchronously zeroes all four counts and takes priority over increments in the same cycle.
- Reset zeroes all four counts.
REQ-026 With DEMUX4_ROUTER_STATS_EN undefined, stat_clr and stat_xfer SHALL not exist, and the remaining behaviour SHALL be identical.

Verification
REQ-027 Reset, then push 0xA5 with sel=2 and out_ready=0 -> after the edge: out_valid=4'b0100, slice 2=0xA5, in_ready stays 1 for sel=2.
REQ-028 Push 0x11 then 0x22 to channel 1 with out_ready=0 -> in_ready=0 for sel=1 and 1 for sel=0. Then set out_ready[1]=1 -> 0x11 pops, then 0x22 pops.
REQ-029 Channel 3 at count 1; push 0x33 to channel 3 with out_ready[3]=1 in the same cycle -> count stays 1 and the head becomes 0x33.
REQ-030 Channel 0 full and stalled; stream 0x01..0x04 to channel 2 with out_ready[2]=1 -> all four emerge in order on channel 2, and channel 0 is unchanged.
REQ-031 Channels 0 and 1 each hold 2 words; pulse resetn low between edges -> out_valid drops to 0 immediately and in_ready=1.
REQ-032 With STATS_EN defined: 300 pushes to channel 0 -> stat_xfer[7:0]=255. Then stat_clr=1 for one cycle -> stat_xfer=0.
